bus_interconnect_rr: RTL and testbench

- Parametrised shared-bus interconnect: NUM_M masters to NUM_S slaves.
- Adds three things the previous generation lacks:
  - fair round-robin arbitration;
  - grant locking for the whole of an outstanding access;
  - a bus-error response for unmapped addresses or slaves that never respond.
- Sits between CPU/DMA masters and the ROM, SPM, timer, UART and GPIO slaves.

---
 rtl/bus_interconnect_rr.sv | 135 +++++++++++++
 tb/tb_bus_interconnect_rr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect_rr.sv
// Shared-bus interconnect: NUM_M masters to NUM_S slaves.
// Round-robin arbitration that only moves while the bus is idle. The grant is
// locked for the whole of an access. Unmapped addresses and slaves that never
// answer complete with a one-cycle bus-error response.
module bus_interconnect_rr #(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 8,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 30,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_req,
  output logic [NUM_M-1:0]          m_grnt,
  input  logic [NUM_M-1:0]          m_as,
  input  logic [NUM_M-1:0]          m_rw,
  input  logic [NUM_M*ADDR_W-1:0]   m_addr,
  input  logic [NUM_M*DATA_W-1:0]   m_wr_data,
  output logic [DATA_W-1:0]         m_rd_data,
  output logic                      m_rdy,
  output logic                      m_err,
  output logic [NUM_S-1:0]          s_cs,
  output logic                      s_as,
  output logic                      s_rw,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wr_data,
  input  logic [NUM_S-1:0]          s_rdy,
  input  logic [NUM_S*DATA_W-1:0]   s_rd_data
);

  localparam int OW = $clog2(NUM_M);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t           state;
  logic [OW-1:0]    owner;
  logic [SEL_W-1:0] lat_idx;
  logic [CW-1:0]    cnt;

  logic [SEL_W-1:0] idx;
  logic             idx_ok;
  logic             own_as;
  logic             lat_rdy;
  logic [OW-1:0]    rr_pick;
  logic             rr_found;

  // Owner-driven master mux and address decode
  always_comb begin
    m_grnt        = '0;
    m_grnt[owner] = 1'b1;
    s_addr        = m_addr[int'(owner)*ADDR_W +: ADDR_W];
    s_wr_data     = m_wr_data[int'(owner)*DATA_W +: DATA_W];
    s_rw          = m_rw[owner];
    own_as        = m_as[owner];
    s_as          = own_as && (state == IDLE);
    idx           = s_addr[ADDR_W-1 -: SEL_W];
    idx_ok        = (int'(idx) < NUM_S);
    lat_rdy       = s_rdy[lat_idx];
  end

  // Chip select: follows the strobe while idle, held on the latched slave while busy
  always_comb begin
    s_cs = '0;
    if (state == IDLE) begin
      if (idx_ok) s_cs[idx] = s_as;
    end else if (state == BUSY) begin
      s_cs[lat_idx] = 1'b1;
    end
  end

  // Completion response; read data is zero outside a ready cycle
  always_comb begin
    m_rdy     = ((state == BUSY) && lat_rdy) || (state == ERR);
    m_err     = (state == ERR);
    m_rd_data = '0;
    if ((state == BUSY) && lat_rdy)
      m_rd_data = s_rd_data[int'(lat_idx)*DATA_W +: DATA_W];
  end

  // Round-robin search: first requester after the current owner, wrapping
  always_comb begin
    int cand;
    cand     = 0;
    rr_pick  = owner;
    rr_found = 1'b0;
    for (int i = 1; i < NUM_M; i++) begin
      cand = (int'(owner) + i) % NUM_M;
      if (!rr_found && m_req[cand]) begin
        rr_found = 1'b1;
        rr_pick  = OW'(cand);
      end
    end
  end

  // Access state machine with ownership frozen outside IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      cnt     <= '0;
      lat_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (own_as) begin
            if (idx_ok) begin
              lat_idx <= idx;
              cnt     <= '0;
              state   <= BUSY;
            end else begin
              state   <= ERR;
            end
          end else if (!m_req[owner] && rr_found) begin
            owner <= rr_pick;
          end
        end
        BUSY: begin
          // a ready in the expiry cycle still completes normally
          if (lat_rdy)
            state <= IDLE;
          else if (cnt == CW'(TIMEOUT - 1))
            state <= ERR;
          else
            cnt <= cnt + CW'(1);
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect_rr.sv
// Directed bench for bus_interconnect_rr (4 masters, 5 slaves, timeout 4).
module tb_bus_interconnect_rr;

  localparam int NM = 4;
  localparam int NS = 5;
  localparam int DW = 32;
  localparam int AW = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req, m_grnt, m_as, m_rw;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wr_data;
  logic [DW-1:0]     m_rd_data;
  logic              m_rdy, m_err;
  logic [NS-1:0]     s_cs;
  logic              s_as, s_rw;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wr_data;
  logic [NS-1:0]     s_rdy;
  logic [NS*DW-1:0]  s_rd_data;

  int vectors = 0;
  int miscompares = 0;

  bus_interconnect_rr #(
    .NUM_M(NM), .NUM_S(NS), .DATA_W(DW), .ADDR_W(AW), .SEL_W(3), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_grnt(m_grnt), .m_as(m_as),
    .m_rw(m_rw), .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
    .m_rdy(m_rdy), .m_err(m_err), .s_cs(s_cs), .s_as(s_as), .s_rw(s_rw),
    .s_addr(s_addr), .s_wr_data(s_wr_data), .s_rdy(s_rdy), .s_rd_data(s_rd_data)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; m_req = '0; m_as = '0; m_rw = '0; m_addr = '0;
    m_wr_data = '0; s_rdy = '0; s_rd_data = '0;
    nxt(); nxt();
    #2;
    chk("rst_grnt", 64'(m_grnt), 64'h1);
    chk("rst_rdy",  64'(m_rdy),  64'h0);
    chk("rst_err",  64'(m_err),  64'h0);
    chk("rst_s_as", 64'(s_as),   64'h0);
    chk("rst_s_cs", 64'(s_cs),   64'h0);

    // request during reset is ignored, served one cycle after release
    m_req = 4'b0100;
    nxt(); #2;
    chk("rst_hold_grnt", 64'(m_grnt), 64'h1);
    rst = 1'b0;
    nxt(); #2;
    chk("grant_m2", 64'(m_grnt), 64'b0100);
    m_req = 4'b0000;
    nxt(); #2;
    chk("park_m2", 64'(m_grnt), 64'b0100);

    // round-robin order
    m_req = 4'b0010;
    nxt(); #2;
    chk("grant_m1", 64'(m_grnt), 64'b0010);
    m_req = 4'b1011;
    nxt(); #2;
    chk("hold_m1", 64'(m_grnt), 64'b0010);
    m_req = 4'b1001;
    nxt(); #2;
    chk("rr_m3_before_m0", 64'(m_grnt), 64'b1000);
    m_req = 4'b0001;
    nxt(); #2;
    chk("rr_m0", 64'(m_grnt), 64'b0001);

    // master 0 read of slave 2, ready on third busy cycle; master 1 strobe ignored
    m_addr[0 +: AW] = 30'h1000_0004;
    m_wr_data[0 +: DW] = 32'h1234_5678;
    m_rw = 4'b0001;
    m_as = 4'b0011;
    #2;
    chk("strobe_s_as",   64'(s_as),      64'h1);
    chk("strobe_s_cs",   64'(s_cs),      64'b00100);
    chk("strobe_s_addr", 64'(s_addr),    64'h1000_0004);
    chk("strobe_s_rw",   64'(s_rw),      64'h1);
    chk("strobe_s_wd",   64'(s_wr_data), 64'h1234_5678);
    nxt();
    m_as = '0;
    s_rd_data[2*DW +: DW] = 32'hDEAD_BEEF;
    #2;
    chk("b1_s_cs",  64'(s_cs),      64'b00100);
    chk("b1_s_as",  64'(s_as),      64'h0);
    chk("b1_rdy",   64'(m_rdy),     64'h0);
    chk("b1_rdata", 64'(m_rd_data), 64'h0);
    nxt(); #2;
    chk("b2_rdy",  64'(m_rdy), 64'h0);
    chk("b2_s_cs", 64'(s_cs),  64'b00100);
    nxt();
    s_rdy = 5'b00100;
    s_rd_data[2*DW +: DW] = 32'hCAFE_F00D;
    #2;
    chk("b3_rdy",   64'(m_rdy),     64'h1);
    chk("b3_rdata", 64'(m_rd_data), 64'hCAFE_F00D);
    chk("b3_err",   64'(m_err),     64'h0);
    chk("b3_s_cs",  64'(s_cs),      64'b00100);
    nxt();
    s_rdy = '0;
    #2;
    chk("done_rdy",   64'(m_rdy),     64'h0);
    chk("done_s_cs",  64'(s_cs),      64'h0);
    chk("done_rdata", 64'(m_rd_data), 64'h0);

    // strobe from a non-owner is dropped
    m_as = 4'b0100;
    #2;
    chk("nonown_s_as", 64'(s_as), 64'h0);
    chk("nonown_s_cs", 64'(s_cs), 64'h0);
    nxt();
    m_as = '0;
    #2;
    chk("nonown_idle_cs", 64'(s_cs), 64'h0);

    // slave 1 never ready: error five cycles after the strobe
    m_addr[0 +: AW] = 30'h0800_0000;
    s_rd_data[1*DW +: DW] = 32'h5555_AAAA;
    m_as = 4'b0001;
    #2;
    chk("to_strobe_cs", 64'(s_cs), 64'b00010);
    nxt();
    m_as = '0;
    for (int k = 1; k <= 4; k++) begin
      #2;
      chk($sformatf("to_busy%0d_rdy", k), 64'(m_rdy), 64'h0);
      chk($sformatf("to_busy%0d_cs", k),  64'(s_cs),  64'b00010);
      nxt();
    end
    #2;
    chk("to_err_rdy",   64'(m_rdy),     64'h1);
    chk("to_err_err",   64'(m_err),     64'h1);
    chk("to_err_rdata", 64'(m_rd_data), 64'h0);
    chk("to_err_cs",    64'(s_cs),      64'h0);
    nxt(); #2;
    chk("to_after_rdy", 64'(m_rdy), 64'h0);
    chk("to_after_err", 64'(m_err), 64'h0);

    // ready in the expiry cycle wins over the timeout
    m_as = 4'b0001;
    nxt();
    m_as = '0;
    nxt(); nxt(); nxt();
    s_rdy = 5'b00010;
    #2;
    chk("tie_rdy",   64'(m_rdy),     64'h1);
    chk("tie_err",   64'(m_err),     64'h0);
    chk("tie_rdata", 64'(m_rd_data), 64'h5555_AAAA);
    nxt();
    s_rdy = '0;
    #2;
    chk("tie_after_rdy", 64'(m_rdy), 64'h0);
    chk("tie_after_err", 64'(m_err), 64'h0);

    // unmapped slave index 6
    m_addr[0 +: AW] = 30'h3000_0000;
    m_as = 4'b0001;
    #2;
    chk("unmap_s_cs", 64'(s_cs),  64'h0);
    chk("unmap_s_as", 64'(s_as),  64'h1);
    chk("unmap_rdy0", 64'(m_rdy), 64'h0);
    nxt();
    m_as = '0;
    #2;
    chk("unmap_rdy",   64'(m_rdy),     64'h1);
    chk("unmap_err",   64'(m_err),     64'h1);
    chk("unmap_rdata", 64'(m_rd_data), 64'h0);
    nxt(); #2;
    chk("unmap_after_rdy", 64'(m_rdy), 64'h0);

    // grant lock: master 0 drops and master 2 requests during the access
    m_addr[0 +: AW] = 30'h1000_0004;
    m_as = 4'b0001;
    nxt();
    m_as = '0;
    m_req = 4'b0100;
    #2;
    chk("lock_b1_grnt", 64'(m_grnt), 64'b0001);
    nxt(); #2;
    chk("lock_b2_grnt", 64'(m_grnt), 64'b0001);
    nxt();
    s_rdy = 5'b00100;
    #2;
    chk("lock_b3_rdy",  64'(m_rdy),  64'h1);
    chk("lock_b3_grnt", 64'(m_grnt), 64'b0001);
    nxt();
    s_rdy = '0;
    #2;
    chk("lock_idle_grnt", 64'(m_grnt), 64'b0001);
    nxt(); #2;
    chk("lock_switch_grnt", 64'(m_grnt), 64'b0100);

    // reset mid-access abandons it silently
    m_addr[2*AW +: AW] = 30'h1000_0004;
    m_as = 4'b0100;
    nxt();
    m_as = '0;
    rst = 1'b1;
    nxt();
    s_rdy = 5'b00100;
    #2;
    chk("midrst_rdy",  64'(m_rdy),  64'h0);
    chk("midrst_err",  64'(m_err),  64'h0);
    chk("midrst_grnt", 64'(m_grnt), 64'b0001);
    chk("midrst_s_cs", 64'(s_cs),   64'h0);
    rst = 1'b0;
    s_rdy = '0;
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
